spi_frame_reader: RTL and testbench

- SPI peripheral (mode 0, MSB first) that streams the completed 1-bit-per-pixel frame out of the ping-pong SPRAM buffer to the MCU.
- Sits directly downstream of the buffer's SPI read side:
  - drives its byte read address;
  - consumes its 8-bit read data and buffer_ready flag;
  - returns frame_read_complete so the buffer can release the frame.
- External SPI pins are oversampled in the single system clock domain.

---
 rtl/spi_frame_reader_if.sv | 22 ++
 rtl/spi_frame_reader.sv | 154 +++++++++++++++
 tb/tb_spi_frame_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_reader_if.sv
// Signal bundle between the frame reader, the SPI pins and the ping-pong
// buffer read port. The slave side is the reader itself.
interface spi_frame_reader_if;
  logic        sck;
  logic        cs_n;
  logic        miso;
  logic [16:0] spi_rd_addr;
  logic [7:0]  spi_rd_data;
  logic        buffer_ready;
  logic        frame_read_complete;
  logic        xfer_active;

  modport slave (
    input  sck, cs_n, spi_rd_data, buffer_ready,
    output miso, spi_rd_addr, frame_read_complete, xfer_active
  );

  modport master (
    output sck, cs_n, spi_rd_data, buffer_ready,
    input  miso, spi_rd_addr, frame_read_complete, xfer_active
  );
endinterface

// File: rtl/spi_frame_reader.sv
// SPI mode-0 peripheral that streams a header byte and then one completed
// 1-bpp frame from the ping-pong buffer, with SPI pins oversampled on sys_clk.
module spi_frame_reader #(
  parameter int unsigned FRAME_BYTES = 2400,
  parameter int unsigned RD_LATENCY  = 2,
  parameter logic [7:0]  HDR_READY   = 8'hA5,
  parameter logic [7:0]  HDR_EMPTY   = 8'h00
) (
  input logic          sys_clk,
  input logic          reset,
  spi_frame_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HEADER, DATA, TRAIL, DONE} state_e;

  localparam logic [16:0] LAST_ADDR = 17'(FRAME_BYTES - 1);
  localparam logic [16:0] FRAME_CNT = 17'(FRAME_BYTES);
  localparam logic [2:0]  LAT       = 3'(RD_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  sck_q, sck_d;     // [0],[1] synchronizer, [2] edge history
  logic [2:0]  cs_q, cs_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [16:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  prefetch_q, prefetch_d;
  logic [16:0] addr_q, addr_d;
  logic [2:0]  lat_q, lat_d;
  logic        ready_l_q, ready_l_d;
  logic        done_q, done_d;

  logic sck_fall, cs_fall, cs_rise, advance;

  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    sck_d      = {sck_q[1:0], bus.sck};
    cs_d       = {cs_q[1:0], bus.cs_n};
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    prefetch_d = prefetch_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    ready_l_d  = ready_l_q;
    done_d     = 1'b0;
    advance    = 1'b0;

    if (lat_q != 3'd0) begin
      lat_d = lat_q - 3'd1;
      if (lat_q == 3'd1) prefetch_d = bus.spi_rd_data;
    end

    case (state_q)
      IDLE: begin
        shift_d    = bus.buffer_ready ? HDR_READY : HDR_EMPTY;
        addr_d     = '0;
        prefetch_d = bus.spi_rd_data;
        lat_d      = '0;
        // A simultaneous sck edge is dropped simply because IDLE ignores sck.
        if (cs_fall) begin
          ready_l_d  = bus.buffer_ready;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = HEADER;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d = IDLE;
          addr_d  = '0;
          lat_d   = '0;
          done_d  = (state_q == DONE);
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            bit_cnt_d = '0;
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 17'd1;
            shift_d = 8'hFF;
            case (state_q)
              HEADER: begin
                if (ready_l_q) begin
                  state_d = DATA;
                  shift_d = prefetch_q;
                  advance = 1'b1;
                end else begin
                  state_d = TRAIL;
                end
              end
              DATA: begin
                // byte_cnt counts the header, so it equals FRAME_BYTES once
                // the last frame byte has been loaded.
                if (byte_cnt_q >= FRAME_CNT) begin
                  state_d = DONE;
                end else begin
                  shift_d = prefetch_q;
                  advance = 1'b1;
                end
              end
              default: ;
            endcase
            if (advance) begin
              if (addr_q != LAST_ADDR) addr_d = addr_q + 17'd1;
              lat_d = LAT;
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sck_q      <= 3'b000;
      cs_q       <= 3'b111;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      prefetch_q <= '0;
      addr_q     <= '0;
      lat_q      <= '0;
      ready_l_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      prefetch_q <= prefetch_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      ready_l_q  <= ready_l_d;
      done_q     <= done_d;
    end
  end

  assign bus.miso                = shift_q[7];
  assign bus.spi_rd_addr         = addr_q;
  assign bus.frame_read_complete = done_q;
  assign bus.xfer_active         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_reader.sv
// Self-checking bench: an MCU-side SPI master reads frames from a 4-byte
// buffer model; received bytes are checked against a scoreboard queue.
module tb_spi_frame_reader;

  localparam int FB = 4;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  spi_frame_reader_if bus ();

  spi_frame_reader #(
    .FRAME_BYTES(FB),
    .RD_LATENCY (2),
    .HDR_READY  (8'hA5),
    .HDR_EMPTY  (8'h00)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  // Buffer model: one register stage, so data follows the address by 2 cycles
  // at the reader's capture point.
  logic [7:0] mem [FB];
  initial begin
    mem[0] = 8'h3C; mem[1] = 8'h81; mem[2] = 8'hFF; mem[3] = 8'h00;
  end
  always @(posedge sys_clk)
    bus.spi_rd_data <= (bus.spi_rd_addr < 17'(FB)) ? mem[bus.spi_rd_addr[1:0]] : 8'hEE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  logic [16:0] max_addr = '0;
  logic [7:0] exp_q [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus.frame_read_complete === 1'b1) begin
      pulse_cnt      = pulse_cnt + 1;
      last_pulse_cyc = cyc;
    end
    if (bus.spi_rd_addr > max_addr) max_addr = bus.spi_rd_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic sck_bit(output logic b);
    bus.sck = 1'b1;
    b = bus.miso;
    wait_neg(8);
    bus.sck = 1'b0;
    wait_neg(8);
  endtask

  task automatic read_byte(input string name);
    logic [7:0] got;
    logic b;
    logic [7:0] want;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(b);
      got[i] = b;
    end
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'(got), 32'hFFFF_FFFF);
    end else begin
      want = exp_q.pop_front();
      check(name, 32'(got), 32'(want));
    end
  endtask

  typedef struct {
    logic        rdy;
    int          nbytes;
    int          toggle_at;     // flip buffer_ready after this byte, -1 = never
    logic [63:0] stream;        // expected bytes, first byte in the MSBs
    int          pulses;
    logic [16:0] max_addr;
  } vec_t;

  task automatic run_txn(input vec_t v, input int idx);
    int p0;
    int rise_cyc;
    string nm;
    bus.buffer_ready = v.rdy;
    wait_neg(10);
    for (int i = 0; i < v.nbytes; i++) exp_q.push_back(v.stream[63 - 8*i -: 8]);
    p0 = pulse_cnt;
    max_addr = '0;
    bus.cs_n = 1'b0;
    wait_neg(8);
    for (int i = 0; i < v.nbytes; i++) begin
      nm = $sformatf("v%0d_byte%0d", idx, i);
      read_byte(nm);
      if (i == v.toggle_at) bus.buffer_ready = ~bus.buffer_ready;
    end
    check($sformatf("v%0d_active", idx), 32'(bus.xfer_active), 32'd1);
    bus.cs_n = 1'b1;
    rise_cyc = cyc;
    wait_neg(12);
    check($sformatf("v%0d_pulses", idx), 32'(pulse_cnt - p0), 32'(v.pulses));
    if (v.pulses == 1)
      check($sformatf("v%0d_pulse_lat", idx),
            32'((last_pulse_cyc - rise_cyc >= 3) && (last_pulse_cyc - rise_cyc <= 4)), 32'd1);
    check($sformatf("v%0d_max_addr", idx), 32'(max_addr), 32'(v.max_addr));
    check($sformatf("v%0d_idle", idx), 32'(bus.xfer_active), 32'd0);
    check($sformatf("v%0d_addr0", idx), 32'(bus.spi_rd_addr), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [7];
  vec_t rvec;
  logic b;
  int p0;

  initial begin
    vecs[0] = '{rdy:1'b0, nbytes:3, toggle_at:-1, stream:64'h00FFFF0000000000, pulses:0, max_addr:17'd0};
    vecs[1] = '{rdy:1'b1, nbytes:5, toggle_at:-1, stream:64'hA53C81FF00000000, pulses:1, max_addr:17'd3};
    vecs[2] = '{rdy:1'b1, nbytes:7, toggle_at:-1, stream:64'hA53C81FF00FFFF00, pulses:1, max_addr:17'd3};
    vecs[3] = '{rdy:1'b1, nbytes:3, toggle_at:-1, stream:64'hA53C810000000000, pulses:0, max_addr:17'd3};
    vecs[4] = '{rdy:1'b1, nbytes:5, toggle_at:-1, stream:64'hA53C81FF00000000, pulses:1, max_addr:17'd3};
    vecs[5] = '{rdy:1'b1, nbytes:5, toggle_at:0,  stream:64'hA53C81FF00000000, pulses:1, max_addr:17'd3};
    vecs[6] = '{rdy:1'b0, nbytes:4, toggle_at:1,  stream:64'h00FFFFFF00000000, pulses:0, max_addr:17'd0};

    bus.sck = 1'b0;
    bus.cs_n = 1'b1;
    bus.buffer_ready = 1'b0;
    reset = 1'b1;
    wait_neg(3);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_addr", 32'(bus.spi_rd_addr), 32'd0);
    check("rst_frc", 32'(bus.frame_read_complete), 32'd0);
    check("rst_active", 32'(bus.xfer_active), 32'd0);
    reset = 1'b0;
    wait_neg(5);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Reset in the middle of the first data byte.
    bus.buffer_ready = 1'b1;
    wait_neg(10);
    check("idle_hdr_msb", 32'(bus.miso), 32'd1);
    p0 = pulse_cnt;
    exp_q.push_back(8'hA5);
    bus.cs_n = 1'b0;
    wait_neg(8);
    read_byte("rst_seq_hdr");
    for (int i = 0; i < 4; i++) sck_bit(b);
    check("rst_seq_active", 32'(bus.xfer_active), 32'd1);
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rst_seq_miso", 32'(bus.miso), 32'd0);
    check("rst_seq_active0", 32'(bus.xfer_active), 32'd0);
    check("rst_seq_addr", 32'(bus.spi_rd_addr), 32'd0);
    bus.cs_n = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(12);
    check("rst_seq_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    rvec = '{rdy:1'b1, nbytes:5, toggle_at:-1, stream:64'hA53C81FF00000000, pulses:1, max_addr:17'd3};
    run_txn(rvec, 7);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
